// File: rtl/mlp_pkg.sv
// Shared definitions for the MLP classifier front-end.
//   - Default frame geometry (feature count, feature width, class width).
//     The classifier generator uses the same constants, so both sides
//     agree on the width of the flat input word.
//   - Sequencer state enum.
//   - Lane-index width helper: $clog2(N_FEAT), at least 1 bit.
package mlp_pkg;

    localparam int MLP_N_FEAT = 4;
    localparam int MLP_FEAT_W = 4;
    localparam int MLP_CLS_W  = 2;

    // A single-lane frame still needs a 1-bit index register.
    function automatic int lane_idx_w(input int n_feat);
        return (n_feat > 1) ? $clog2(n_feat) : 1;
    endfunction

    localparam int MLP_LANE_IDX_W = lane_idx_w(MLP_N_FEAT);

    typedef enum logic [1:0] {
        SEQ_LOAD   = 2'd0,
        SEQ_SETTLE = 2'd1,
        SEQ_HOLD   = 2'd2
    } seq_state_e;

endpackage

// File: rtl/mlp_lane_packer.sv
// Packs a serial feature stream into the classifier's flat input word.
//   clk, rst    : clock, synchronous active-high reset
//   beat_acc    : a feature beat is accepted on this edge
//   feat_data   : feature value of the accepted beat
//   feat_last   : accepted beat is marked as the last of its frame
//   err_clr     : clear the framing-error flag (result captured)
//   lanes       : packed word, lane i in bits [i*FEAT_W +: FEAT_W]
//   frame_end   : the accepted beat closes the frame (combinational)
//   err         : framing error seen in the frame being processed
module mlp_lane_packer
    import mlp_pkg::*;
#(
    parameter int N_FEAT = MLP_N_FEAT,
    parameter int FEAT_W = MLP_FEAT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     beat_acc,
    input  logic [FEAT_W-1:0]        feat_data,
    input  logic                     feat_last,
    input  logic                     err_clr,
    output logic [N_FEAT*FEAT_W-1:0] lanes,
    output logic                     frame_end,
    output logic                     err
);

    localparam int               IDX_W    = lane_idx_w(N_FEAT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);

    logic [IDX_W-1:0] idx;
    logic             at_last_lane;
    logic             bad_framing;

    assign at_last_lane = (idx == LAST_IDX);
    assign frame_end    = beat_acc & (at_last_lane | feat_last);

    // Only meaningful when frame_end is high: on the final lane the beat
    // must carry last (missing last otherwise); before the final lane the
    // frame only ends because last arrived early.
    assign bad_framing = at_last_lane ? ~feat_last : feat_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
        end else if (beat_acc) begin
            idx <= frame_end ? '0 : idx + 1'b1;
        end
    end

    // frame_end (LOAD) and err_clr (SETTLE) never coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (frame_end) begin
            err <= bad_framing;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

    // The first beat of a frame also clears the upper lanes, so an early
    // last leaves them at zero instead of stale data from the previous frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            lanes <= '0;
        end else if (beat_acc) begin
            for (int k = 0; k < N_FEAT; k++) begin
                if (idx == IDX_W'(k)) begin
                    lanes[k*FEAT_W +: FEAT_W] <= feat_data;
                end else if (idx == '0) begin
                    lanes[k*FEAT_W +: FEAT_W] <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/mlp_frame_sequencer.sv
// Producer/consumer wrapper around the combinational MLP classifier.
// Collects a frame of features from a serial stream, holds the packed word
// on mlp_inp for SETTLE_CYC cycles, captures mlp_out and returns it on the
// result channel.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A source holds valid and its payload until that edge; ready
// may be low at any time without consequence for the source.
//
//   clk, rst         : clock, synchronous active-high reset
//   feat_valid/ready : feature beat handshake, feat_data/feat_last payload
//   mlp_inp          : packed word to classifier (lane i at [i*FEAT_W +: FEAT_W])
//   mlp_out          : class index from classifier
//   res_valid/ready  : result handshake, res_class/res_err payload
//   frame_cnt        : number of results produced, wraps at 2^CNT_W
module mlp_frame_sequencer
    import mlp_pkg::*;
#(
    parameter int N_FEAT     = MLP_N_FEAT,
    parameter int FEAT_W     = MLP_FEAT_W,
    parameter int CLS_W      = MLP_CLS_W,
    parameter int SETTLE_CYC = 2,
    parameter int CNT_W      = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     feat_valid,
    output logic                     feat_ready,
    input  logic [FEAT_W-1:0]        feat_data,
    input  logic                     feat_last,
    output logic [N_FEAT*FEAT_W-1:0] mlp_inp,
    input  logic [CLS_W-1:0]         mlp_out,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [CLS_W-1:0]         res_class,
    output logic                     res_err,
    output logic [CNT_W-1:0]         frame_cnt
);

    localparam int                SCNT_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SCNT_W-1:0] SCNT_LOAD = SCNT_W'(SETTLE_CYC - 1);

    seq_state_e        state;
    seq_state_e        state_nxt;
    logic [SCNT_W-1:0] settle_cnt;
    logic              beat_acc;
    logic              frame_end;
    logic              capture;
    logic              err;

    mlp_lane_packer #(
        .N_FEAT (N_FEAT),
        .FEAT_W (FEAT_W)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .beat_acc  (beat_acc),
        .feat_data (feat_data),
        .feat_last (feat_last),
        .err_clr   (capture),
        .lanes     (mlp_inp),
        .frame_end (frame_end),
        .err       (err)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEQ_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            SEQ_LOAD:   if (frame_end)          state_nxt = SEQ_SETTLE;
            SEQ_SETTLE: if (settle_cnt == '0)   state_nxt = SEQ_HOLD;
            SEQ_HOLD:   if (res_ready)          state_nxt = SEQ_LOAD;
            default:                            state_nxt = SEQ_LOAD;
        endcase
    end

    // State-decoded outputs and strobes
    always_comb begin
        feat_ready = (state == SEQ_LOAD);
        beat_acc   = feat_ready & feat_valid;
        capture    = (state == SEQ_SETTLE) && (settle_cnt == '0);
    end

    // Settle counter: loaded on frame end so the capture lands exactly
    // SETTLE_CYC edges after the edge that accepted the final beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_cnt <= '0;
        end else if (frame_end) begin
            settle_cnt <= SCNT_LOAD;
        end else if (state == SEQ_SETTLE && settle_cnt != '0) begin
            settle_cnt <= settle_cnt - 1'b1;
        end
    end

    // Result register
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_class <= '0;
            res_err   <= 1'b0;
            frame_cnt <= '0;
        end else if (capture) begin
            res_valid <= 1'b1;
            res_class <= mlp_out;
            res_err   <= err;
            frame_cnt <= frame_cnt + 1'b1;
        end else if (state == SEQ_HOLD && res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mlp_frame_sequencer.sv
// Testbench for mlp_frame_sequencer with the default geometry
// (4 features x 4 bits, 2-bit class, SETTLE_CYC=2, 8-bit counter).
// The classifier is stood in for by a sum-of-features mod 4 function.
module tb_mlp_frame_sequencer;

    localparam int N_FEAT     = 4;
    localparam int FEAT_W     = 4;
    localparam int CLS_W      = 2;
    localparam int SETTLE_CYC = 2;
    localparam int CNT_W      = 8;

    // ---------------- clock / reset / DUT ----------------
    logic                     clk = 1'b0;
    logic                     rst;
    logic                     feat_valid;
    logic                     feat_ready;
    logic [FEAT_W-1:0]        feat_data;
    logic                     feat_last;
    logic [N_FEAT*FEAT_W-1:0] mlp_inp;
    logic [CLS_W-1:0]         mlp_out;
    logic                     res_valid;
    logic                     res_ready;
    logic [CLS_W-1:0]         res_class;
    logic                     res_err;
    logic [CNT_W-1:0]         frame_cnt;

    always #5 clk = ~clk;

    mlp_frame_sequencer #(
        .N_FEAT     (N_FEAT),
        .FEAT_W     (FEAT_W),
        .CLS_W      (CLS_W),
        .SETTLE_CYC (SETTLE_CYC),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .feat_valid (feat_valid),
        .feat_ready (feat_ready),
        .feat_data  (feat_data),
        .feat_last  (feat_last),
        .mlp_inp    (mlp_inp),
        .mlp_out    (mlp_out),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_class  (res_class),
        .res_err    (res_err),
        .frame_cnt  (frame_cnt)
    );

    // Classifier stand-in: sum of the feature lanes, modulo 4.
    function automatic logic [1:0] cls_of(input logic [15:0] w);
        logic [5:0] s;
        s = 6'd0;
        for (int k = 0; k < N_FEAT; k++) s = s + 6'(w[k*4 +: 4]);
        return s[1:0];
    endfunction

    assign mlp_out = cls_of(mlp_inp);

    // ---------------- scoreboard state ----------------
    int          total = 0;
    int          bad   = 0;
    logic [7:0]  exp_cnt = 8'd0;

    logic [3:0]  stim_d[$];
    bit          stim_l[$];
    bit          end_q[$];
    logic [15:0] exp_q[$];
    bit          exp_err_q[$];

    // Reference model: walks the beat list, splitting it into frames by
    // counting lanes, and records the expected word and error per frame.
    task automatic model_build();
        int          lane;
        logic [15:0] w;
        lane = 0;
        w    = 16'h0;
        end_q.delete();
        foreach (stim_d[k]) begin
            if (lane == 0) w = 16'h0;
            w[lane*4 +: 4] = stim_d[k];
            lane++;
            if (stim_l[k] || lane == N_FEAT) begin
                exp_q.push_back(w);
                exp_err_q.push_back((lane != N_FEAT) || !stim_l[k]);
                end_q.push_back(1'b1);
                lane = 0;
            end else begin
                end_q.push_back(1'b0);
            end
        end
    endtask

    task automatic stim_clear();
        stim_d.delete();
        stim_l.delete();
    endtask

    // ---------------- driver tasks ----------------
    // Entered and left 1 time unit after a rising edge; returns just after
    // the edge that accepted the beat.
    task automatic send_beat(input logic [3:0] d, input bit l);
        int guard;
        guard      = 0;
        feat_valid = 1'b1;
        feat_data  = d;
        feat_last  = l;
        while (!feat_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 100) begin
            total++; bad++;
            $display("FAIL beat_accept_timeout: feat_ready=%0b after %0d cycles, want 1", feat_ready, guard);
        end
        @(posedge clk); #1;
        feat_valid = 1'b0;
        feat_last  = 1'b0;
    endtask

    // Scoreboard: waits for the next result, compares it with the head of the
    // expected queue, holds off res_ready a random while, then hands it off.
    task automatic sb_check_result();
        int          n;
        int          hold;
        logic [15:0] w;
        bit          e;
        logic [1:0]  c;
        n = 0;
        w = exp_q.pop_front();
        e = exp_err_q.pop_front();
        c = cls_of(w);
        exp_cnt = exp_cnt + 8'd1;
        while (!res_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        // SETTLE_CYC edges after the accept edge == visible in cycle SETTLE_CYC+1.
        total++;
        if (n != SETTLE_CYC) begin
            bad++; $display("FAIL latency: got %0d edges, want %0d", n, SETTLE_CYC);
        end
        total++;
        if (mlp_inp !== w) begin
            bad++; $display("FAIL mlp_inp: got %h, want %h", mlp_inp, w);
        end
        total++;
        if (res_class !== c) begin
            bad++; $display("FAIL res_class: got %0d, want %0d", res_class, c);
        end
        total++;
        if (res_err !== e) begin
            bad++; $display("FAIL res_err: got %0b, want %0b", res_err, e);
        end
        total++;
        if (frame_cnt !== exp_cnt) begin
            bad++; $display("FAIL frame_cnt: got %0d, want %0d", frame_cnt, exp_cnt);
        end
        hold = $urandom_range(0, 2);
        repeat (hold) begin
            @(posedge clk); #1;
            total++;
            if (res_valid !== 1'b1 || res_class !== c || feat_ready !== 1'b0) begin
                bad++; $display("FAIL hold_stable: valid=%0b class=%0d ready=%0b, want 1 %0d 0",
                                res_valid, res_class, feat_ready, c);
            end
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        total++;
        if (res_valid !== 1'b0 || feat_ready !== 1'b1) begin
            bad++; $display("FAIL handoff: valid=%0b ready=%0b, want 0 1", res_valid, feat_ready);
        end
    endtask

    task automatic run_stream();
        model_build();
        foreach (stim_d[k]) begin
            send_beat(stim_d[k], stim_l[k]);
            if (end_q[k]) sb_check_result();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_cnt = 8'd0;
        exp_q.delete();
        exp_err_q.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        feat_valid = 1'b0; feat_data = 4'h0; feat_last = 1'b0; res_ready = 1'b0;
        do_reset();
        total++;
        if (mlp_inp !== 16'h0) begin bad++; $display("FAIL reset_mlp_inp: got %h, want 0000", mlp_inp); end
        total++;
        if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid: got %0b, want 0", res_valid); end
        total++;
        if (res_class !== 2'd0 || res_err !== 1'b0) begin
            bad++; $display("FAIL reset_result: class=%0d err=%0b, want 0 0", res_class, res_err);
        end
        total++;
        if (frame_cnt !== 8'd0) begin bad++; $display("FAIL reset_frame_cnt: got %0d, want 0", frame_cnt); end
        total++;
        if (feat_ready !== 1'b1) begin bad++; $display("FAIL reset_feat_ready: got %0b, want 1", feat_ready); end
    endtask

    task automatic test_nominal();
        stim_clear();
        stim_d = '{4'h8, 4'h8, 4'hA, 4'h4};
        stim_l = '{1'b0, 1'b0, 1'b0, 1'b1};
        run_stream();
        // Word is kept through LOAD until the next frame's first beat.
        total++;
        if (mlp_inp !== 16'h4A88) begin bad++; $display("FAIL nominal_word_held: got %h, want 4a88", mlp_inp); end
        total++;
        if (frame_cnt !== 8'd1) begin bad++; $display("FAIL nominal_cnt: got %0d, want 1", frame_cnt); end
    endtask

    task automatic test_early_last();
        stim_clear();
        stim_d = '{4'h3, 4'h5};
        stim_l = '{1'b0, 1'b1};
        for (int k = 0; k < N_FEAT; k++) begin
            stim_d.push_back(4'($urandom_range(0, 15)));
            stim_l.push_back(k == N_FEAT - 1);
        end
        run_stream();
    endtask

    task automatic test_missing_last();
        stim_clear();
        for (int k = 0; k < N_FEAT; k++) begin
            stim_d.push_back(4'($urandom_range(0, 15)));
            stim_l.push_back(1'b0);
        end
        stim_d.push_back(4'h1);
        stim_l.push_back(1'b1);
        run_stream();
        total++;
        if (mlp_inp !== 16'h0001) begin bad++; $display("FAIL missing_last_word: got %h, want 0001", mlp_inp); end
    endtask

    task automatic test_backpressure();
        logic [15:0] w;
        logic [1:0]  c;
        bit          e;
        int          n;
        n = 0;
        stim_clear();
        for (int k = 0; k < N_FEAT; k++) begin
            stim_d.push_back(4'($urandom_range(0, 14)));
            stim_l.push_back(k == N_FEAT - 1);
        end
        model_build();
        foreach (stim_d[k]) send_beat(stim_d[k], stim_l[k]);
        w = exp_q.pop_front();
        e = exp_err_q.pop_front();
        c = cls_of(w);
        exp_cnt = exp_cnt + 8'd1;
        while (!res_valid && n < 20) begin @(posedge clk); #1; n++; end
        total++;
        if (n != SETTLE_CYC || res_err !== e) begin
            bad++; $display("FAIL bp_first_result: latency=%0d err=%0b, want %0d %0b", n, res_err, SETTLE_CYC, e);
        end
        // Offer a beat the whole time the result is stalled.
        feat_valid = 1'b1; feat_data = 4'hF; feat_last = 1'b1; res_ready = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            total++;
            if (feat_ready !== 1'b0 || res_valid !== 1'b1 || res_class !== c || mlp_inp !== w) begin
                bad++; $display("FAIL bp_stall: ready=%0b valid=%0b class=%0d inp=%h, want 0 1 %0d %h",
                                feat_ready, res_valid, res_class, mlp_inp, c, w);
            end
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        total++;
        if (res_valid !== 1'b0 || mlp_inp !== w) begin
            bad++; $display("FAIL bp_handshake_cycle: valid=%0b inp=%h, want 0 %h", res_valid, mlp_inp, w);
        end
        total++;
        if (feat_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_after: got %0b, want 1", feat_ready); end
        @(posedge clk); #1;
        feat_valid = 1'b0; feat_last = 1'b0;
        total++;
        if (mlp_inp !== 16'h000F) begin bad++; $display("FAIL bp_next_beat: got %h, want 000f", mlp_inp); end
        exp_q.push_back(16'h000F);
        exp_err_q.push_back(1'b1);
        sb_check_result();
    endtask

    task automatic test_random();
        stim_clear();
        for (int k = 0; k < 40; k++) begin
            stim_d.push_back(4'($urandom_range(0, 15)));
            stim_l.push_back($urandom_range(0, 3) == 0);
        end
        stim_l[stim_l.size() - 1] = 1'b1;
        run_stream();
    endtask

    task automatic test_reset_mid_settle();
        stim_clear();
        for (int k = 0; k < N_FEAT; k++) begin
            stim_d.push_back(4'($urandom_range(1, 15)));
            stim_l.push_back(k == N_FEAT - 1);
        end
        foreach (stim_d[k]) send_beat(stim_d[k], stim_l[k]);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cnt = 8'd0;
        total++;
        if (res_valid !== 1'b0 || mlp_inp !== 16'h0) begin
            bad++; $display("FAIL mid_reset_outputs: valid=%0b inp=%h, want 0 0000", res_valid, mlp_inp);
        end
        total++;
        if (frame_cnt !== 8'd0) begin bad++; $display("FAIL mid_reset_cnt: got %0d, want 0", frame_cnt); end
        total++;
        if (feat_ready !== 1'b1) begin bad++; $display("FAIL mid_reset_ready: got %0b, want 1", feat_ready); end
        repeat (SETTLE_CYC + 3) begin
            @(posedge clk); #1;
            total++;
            if (res_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_no_result: valid=%0b, want 0", res_valid); end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int f = 0; f < 256; f++) begin
            stim_clear();
            for (int k = 0; k < N_FEAT; k++) begin
                stim_d.push_back(4'($urandom_range(0, 15)));
                stim_l.push_back(k == N_FEAT - 1);
            end
            run_stream();
        end
        total++;
        if (frame_cnt !== 8'd0) begin bad++; $display("FAIL wrap_cnt: got %0d, want 0", frame_cnt); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        rst = 1'b1;
        feat_valid = 1'b0; feat_data = 4'h0; feat_last = 1'b0; res_ready = 1'b0;
        test_reset();
        test_nominal();
        test_early_last();
        test_missing_last();
        test_backpressure();
        test_random();
        test_reset_mid_settle();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
